// File: rtl/imem_fetch.sv
// Instruction memory with registered read, autonomous sequential fetch PC and a
// prefetch FIFO feeding decode over valid/ready. Supports branch redirect and program load.
module imem_fetch #(
  parameter int    INSTR_WIDTH = 16,
  parameter int    ADDR_WIDTH  = 5,
  parameter int    DEPTH       = 32,
  parameter int    FIFO_DEPTH  = 4,
  parameter string INIT_FILE   = "program.hex"
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              instr_ready,
  output logic                              instr_valid,
  output logic [INSTR_WIDTH-1:0]            instr,
  output logic [ADDR_WIDTH-1:0]             instr_addr,
  input  logic                              redirect_valid,
  input  logic [ADDR_WIDTH-1:0]             redirect_addr,
  output logic                              addr_err,
  input  logic                              prog_we,
  input  logic [ADDR_WIDTH-1:0]             prog_addr,
  input  logic [INSTR_WIDTH-1:0]            prog_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [PW-1:0]         LAST_SLOT = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]           FIFO_LIM  = (CW + 1)'(FIFO_DEPTH);

  if (DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH) || FIFO_DEPTH < 2 || FIFO_DEPTH > 16) begin : g_bad_param
    $error("imem_fetch: DEPTH or FIFO_DEPTH out of legal range");
  end

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0]  fetch_pc;
  logic [ADDR_WIDTH-1:0]  next_pc;
  logic                   rvalid_q;
  logic [ADDR_WIDTH-1:0]  raddr_q;
  logic [INSTR_WIDTH-1:0] rdata_q;

  logic [ADDR_WIDTH-1:0]  fifo_addr [FIFO_DEPTH];
  logic [INSTR_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  logic [CW-1:0]          count;

  logic [CW:0]            occ;
  logic                   issue;
  logic                   pop;
  logic                   redirect_ok;
  logic                   prog_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    occ         = {1'b0, count} + (CW + 1)'(rvalid_q);
    issue       = !redirect_valid && (occ < FIFO_LIM);
    pop         = instr_valid && instr_ready;
    redirect_ok = ({1'b0, redirect_addr} < DEPTH_W);
    prog_ok     = ({1'b0, prog_addr} < DEPTH_W);
    // Explicit wrap keeps the PC inside the array for non power-of-2 depths.
    next_pc     = (fetch_pc == LAST_ADDR) ? '0 : fetch_pc + ADDR_WIDTH'(1);
  end

  // Write port is independent of reset and redirect; the read below sees pre-write data.
  always_ff @(posedge clk) begin
    if (prog_we && prog_ok) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= '0;
      rvalid_q <= 1'b0;
      raddr_q  <= '0;
      rdata_q  <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      addr_err <= 1'b0;
    end else if (redirect_valid) begin
      // Flush drops both queued entries and the in-flight read, including any pop this cycle.
      rvalid_q <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= redirect_ok ? redirect_addr : '0;
      addr_err <= !redirect_ok;
    end else begin
      addr_err <= 1'b0;
      rvalid_q <= issue;
      if (issue) begin
        rdata_q  <= mem[fetch_pc];
        raddr_q  <= fetch_pc;
        fetch_pc <= next_pc;
      end
      if (rvalid_q) begin
        fifo_addr[tail] <= raddr_q;
        fifo_data[tail] <= rdata_q;
        tail            <= ptr_inc(tail);
      end
      if (pop) begin
        head <= ptr_inc(head);
      end
      case ({rvalid_q, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    instr_valid = (count != '0);
    instr       = instr_valid ? fifo_data[head] : '0;
    instr_addr  = instr_valid ? fifo_addr[head] : '0;
    fifo_count  = count;
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Randomized scoreboard bench: two builds (DEPTH 32 and 24) share stimulus; expected
// instruction streams come from a sequential-address memory model per build.
module tb_imem_fetch;

  logic        clk;
  logic        reset;
  logic        instr_ready;
  logic        redirect_valid;
  logic [4:0]  redirect_addr;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;

  logic        iv  [2];
  logic [15:0] ins [2];
  logic [4:0]  ia  [2];
  logic        ae  [2];
  logic [2:0]  fc  [2];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    imem_fetch #(
      .INSTR_WIDTH(16), .ADDR_WIDTH(5), .DEPTH((g == 0) ? 32 : 24),
      .FIFO_DEPTH(4), .INIT_FILE("")
    ) dut (
      .clk(clk), .reset(reset), .instr_ready(instr_ready),
      .instr_valid(iv[g]), .instr(ins[g]), .instr_addr(ia[g]),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .addr_err(ae[g]), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .fifo_count(fc[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [15:0] mm [2][32];
  logic [20:0] q0 [$];
  logic [20:0] q1 [$];
  int  npc      [2];
  int  lat      [2];
  int  low_run  [2];
  bit  exp_err  [2];
  bit  prev_pop [2];
  bit  started = 1'b0;

  function automatic int dep(input int i);
    return (i == 0) ? 32 : 24;
  endfunction

  function automatic void qclear(input int i);
    if (i == 0) q0.delete(); else q1.delete();
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void qpush(input int i, input logic [20:0] v);
    if (i == 0) q0.push_back(v); else q1.push_back(v);
  endfunction

  function automatic logic [20:0] qpop(input int i);
    if (qsize(i) == 0) return 21'h1FFFFF;
    return (i == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  function automatic void chk(input string nm, input int i, input bit ok,
                              input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, i, $time, act, req);
    end
  endfunction

  function automatic void flush(input int i, input int pc);
    qclear(i);
    npc[i] = pc;
    lat[i] = 0;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      npc[i] = 0; lat[i] = 0; low_run[i] = 0; exp_err[i] = 0; prev_pop[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [20:0] e;
      if (lat[i] < 10) lat[i]++;
      if (started) begin
        chk("count_bound", i, fc[i] <= 3'd4, fc[i], 4);
        chk("addr_err", i, ae[i] === exp_err[i], ae[i], exp_err[i]);
        if (iv[i] !== 1'b1)
          chk("empty_zero", i, ins[i] === 16'h0 && ia[i] === 5'h0, {ia[i], ins[i]}, 0);
        if (lat[i] == 1)
          chk("flush_count", i, fc[i] === 3'd0, fc[i], 0);
        if (lat[i] <= 2)
          chk("flush_valid_low", i, iv[i] === 1'b0, iv[i], 0);
        else if (lat[i] == 3)
          chk("first_valid", i, iv[i] === 1'b1, iv[i], 1);
        else if (prev_pop[i])
          chk("no_bubble", i, iv[i] === 1'b1, iv[i], 1);
        if (!instr_ready && lat[i] >= 3) low_run[i]++; else low_run[i] = 0;
        if (low_run[i] >= 5)
          chk("saturate", i, fc[i] === 3'd4 && iv[i] === 1'b1, fc[i], 4);
        if (iv[i] === 1'b1 && instr_ready) begin
          e = qpop(i);
          chk("head_addr", i, ia[i] === e[20:16], ia[i], e[20:16]);
          chk("head_instr", i, ins[i] === e[15:0], ins[i], e[15:0]);
        end
      end
      prev_pop[i] = started && (iv[i] === 1'b1) && instr_ready;
      exp_err[i]  = reset && redirect_valid && (int'(redirect_addr) >= dep(i));
      if (prog_we && int'(prog_addr) < dep(i)) mm[i][prog_addr] = prog_data;
      if (!reset)
        flush(i, 0);
      else if (redirect_valid)
        flush(i, (int'(redirect_addr) < dep(i)) ? int'(redirect_addr) : 0);
      while (qsize(i) < 8) begin
        qpush(i, {5'(npc[i]), mm[i][npc[i]]});
        npc[i] = (npc[i] + 1) % dep(i);
      end
    end
    if (!reset) started = 1'b1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic redirect(input logic [4:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    cyc();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int r;
    reset = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_addr = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    run(2);
    for (int a = 0; a < 32; a++) begin
      prog_we = 1'b1; prog_addr = 5'(a); prog_data = 16'hA000 + 16'(a);
      cyc();
    end
    prog_we = 1'b0;
    run(2);
    reset = 1'b1;
    run(80);
    instr_ready = 1'b0; run(10);
    instr_ready = 1'b1; run(12);
    instr_ready = 1'b0; run(8);
    redirect(5'h10);
    instr_ready = 1'b1; run(10);
    redirect(5'h1A);
    run(30);
    prog_we = 1'b1; prog_addr = 5'd5; prog_data = 16'hBEEF;
    redirect(5'd5);
    prog_we = 1'b0;
    run(6);
    instr_ready = 1'b0; run(2);
    reset = 1'b0; cyc();
    reset = 1'b1; instr_ready = 1'b1;
    run(40);
    for (int n = 0; n < 1500; n++) begin
      instr_ready = ($urandom_range(3) != 0);
      r = $urandom_range(63);
      if (r == 0) begin
        reset = 1'b0;
      end else if (r <= 4) begin
        redirect_valid = 1'b1;
        redirect_addr  = 5'($urandom_range(31));
      end
      if (r <= 4 && $urandom_range(1) == 1) begin
        prog_we   = 1'b1;
        prog_addr = 5'($urandom_range(31));
        prog_data = 16'($urandom);
      end
      if (r == 5) begin
        instr_ready = 1'b0;
        run(7);
      end else begin
        cyc();
      end
      reset = 1'b1; redirect_valid = 1'b0; prog_we = 1'b0;
    end
    run(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
